alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Multi-cycle sequencer that performs 16x16 unsigned multiply (32-bit product) and 16/16 unsigned divide (quotient and remainder) by driving the core's shared 16-bit ALU for one operation per cycle. It sits beside the execute stage. While busy it owns the ALU through `alu_en`, which the core uses to select this block's ALU inputs over the decoder's. Results come back in a hi/lo register pair.

## Interface
- `ITER`, default 16: iteration count; equals operand width; fixed at 16 for this core.
- `DIV0_Q`, default 16'hFFFF: quotient reported on divide-by-zero.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request; sampled only in IDLE.
- `op`, in, 1: 0 = multiply, 1 = divide; sampled with `start`.
- `x`, in, 16: multiplicand or dividend; captured on accept.
- `y`, in, 16: multiplier or divisor; captured on accept.
- `busy`, out, 1: high in MUL, DIV and DONE.
- `done`, out, 1: one-cycle pulse, high in DONE.
- `hi`, out, 16: product[31:16], or remainder.
- `lo`, out, 16: product[15:0], or quotient.
- `dz`, out, 1: divide-by-zero flag of the last operation.
- `alu_en`, out, 1: high in MUL/DIV only; core muxes ALU inputs from this block.
- `alu_op`, out, 4: ALU opcode (0 = add with carry, 1 = subtract with borrow).
- `alu_a`, out, 16: ALU operand a.
- `alu_b`, out, 16: ALU operand b.
- `alu_res`, in, 16: ALU result.
- `alu_c`, in, 1: ALU carry/borrow. For op 0 it is the carry out of bit 15. For op 1 it is 1 when a < b unsigned.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset values: state IDLE; `busy`, `done`, `dz`, `alu_en` = 0; `hi`, `lo`, count = 0. `alu_op`, `alu_a` and `alu_b` are 0 whenever not in MUL/DIV.
- IDLE with `start`=1 accepts the request and latches operand register m/d = `y`. Count is set to 0.
  - `op`=0: `hi`=0, `lo`=`x`, `dz`=0, go to MUL.
  - `op`=1, `y`≠0: `hi`=0, `lo`=`x`, `dz`=0, go to DIV.
  - `op`=1, `y`=0: `hi`=`x`, `lo`=DIV0_Q, `dz`=1, go directly to DONE. No ALU use.
- MUL iteration (each cycle):
  - ALU drive: `alu_op`=0, `alu_a`=`hi`, `alu_b` = `lo`[0] ? m : 0.
  - Update: {`hi`,`lo`} <= {`alu_c`, `alu_res`, `lo`[15:1]}.
- DIV iteration (restoring, each cycle):
  - sh = {`hi`[14:0], `lo`[15]}; r16 = `hi`[15].
  - ALU drive: `alu_op`=1, `alu_a`=sh, `alu_b`=d.
  - ok = r16 | ~`alu_c`. When r16=1 the 17-bit trial always succeeds, and the low 16 bits of `alu_res` are the correct remainder.
  - Update: `hi` <= ok ? `alu_res` : sh; `lo` <= {`lo`[14:0], ok}.
- Count increments once per iteration. After the iteration with count = ITER-1, go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Results: `hi`, `lo` and `dz` are valid from the DONE cycle and are held until the next accepted `start`. During MUL/DIV they hold intermediate values.
- `start` is ignored in MUL, DIV and DONE; there is no queueing. `x`, `y` and `op` are don't-care after accept.
- `rst` asserted at any time forces all reset values immediately, even mid-operation. `alu_en` drops asynchronously, so the core regains the ALU at once.

## Timing
- Accept edge E0 (IDLE, `start`=1). MUL/DIV occupies the cycles after edges E0..E15 (16 ALU cycles). DONE follows E16, and `done` is high in the cycle after E16. Back to IDLE after E17.
- Latency: 17 cycles from accept to `done`. The earliest next accept is at E18, so throughput is one operation per 18 cycles.
- Divide-by-zero: DONE follows E0, so `done` is high 1 cycle after accept.
- The ALU path is combinational within one cycle: registers → `alu_a`/`alu_b` → ALU → `alu_res`/`alu_c` → registers.
- `busy` rises in the cycle after accept and falls when `done` falls.

## Test plan
- Multiply: x=0x1234, y=0x5678, op=0 → after 17 cycles `done`=1, `hi`=0x0626, `lo`=0x0060, `dz`=0. `alu_en` high for exactly 16 cycles.
- Multiply corner: 0xFFFF × 0xFFFF → `hi`=0xFFFE, `lo`=0x0001. Also 0 × 0x1234 → 0x0000/0x0000.
- Divide: x=1000, y=7 → `lo`=0x008E, `hi`=0x0006. And x=0xFFFF, y=0x8001 → `lo`=0x0001, `hi`=0x7FFE, which exercises the r16 path.
- Divide-by-zero: x=0x1234, y=0 → `done` 1 cycle after accept, `dz`=1, `lo`=0xFFFF, `hi`=0x1234. `alu_en` never asserts.
- Request during operation: pulse `start` with new operands at cycles 5 and 17 after an accept → both ignored, first result unchanged. The next `start` in IDLE is accepted normally.
- Reset mid-operation: assert `rst` 8 cycles into a multiply → `busy`, `done`, `alu_en`, `hi` and `lo` go to 0 immediately. After release, 1000/7 completes with the correct result.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: sequential 16x16 unsigned multiply and 16/16 unsigned
// restoring divide, one step per cycle through the core's shared ALU.
// Ports: clk, rst (async, active-high); start/op/x/y request;
//   busy/done status; hi/lo result pair, dz divide-by-zero flag;
//   alu_en/alu_op/alu_a/alu_b drive the shared ALU, alu_res/alu_c return.
module alu_muldiv_seq #(
   parameter int          ITER   = 16,
   parameter logic [15:0] DIV0_Q = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic [15:0] x,
   input  logic [15:0] y,
   output logic        busy,
   output logic        done,
   output logic [15:0] hi,
   output logic [15:0] lo,
   output logic        dz,
   output logic        alu_en,
   output logic [3:0]  alu_op,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   input  logic [15:0] alu_res,
   input  logic        alu_c
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [15:0]   md;
   logic [CW-1:0] cnt;

   logic [15:0] sh;
   logic        r16;
   logic        ok;
   logic        accept;
   logic        div0;

   // Divide step: shift one dividend bit into the partial remainder.
   // r16 is the bit shifted out; if set, the 17-bit trial always fits.
   assign sh     = {hi[14:0], lo[15]};
   assign r16    = hi[15];
   assign ok     = r16 | ~alu_c;
   assign accept = (state == S_IDLE) && start;
   assign div0   = op && (y == 16'd0);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               if (!op)       state_nx = S_MUL;
               else if (div0) state_nx = S_DONE;
               else           state_nx = S_DIV;
            end
         end
         S_MUL,
         S_DIV: begin
            if (cnt == LAST) state_nx = S_DONE;
         end
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs decoded from state; alu_en follows the async-reset state
   always_comb begin
      busy   = (state != S_IDLE);
      done   = (state == S_DONE);
      alu_en = 1'b0;
      alu_op = 4'd0;
      alu_a  = 16'd0;
      alu_b  = 16'd0;
      unique case (state)
         S_MUL: begin
            alu_en = 1'b1;
            alu_op = 4'd0;
            alu_a  = hi;
            alu_b  = lo[0] ? md : 16'd0;
         end
         S_DIV: begin
            alu_en = 1'b1;
            alu_op = 4'd1;
            alu_a  = sh;
            alu_b  = md;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi  <= 16'd0;
         lo  <= 16'd0;
         md  <= 16'd0;
         dz  <= 1'b0;
         cnt <= '0;
      end else begin
         if (accept) begin
            md  <= y;
            cnt <= '0;
            if (div0) begin
               hi <= x;
               lo <= DIV0_Q;
               dz <= 1'b1;
            end else begin
               hi <= 16'd0;
               lo <= x;
               dz <= 1'b0;
            end
         end else if (state == S_MUL) begin
            // Shift-add: carry and sum enter the top, multiplier bit leaves
            {hi, lo} <= {alu_c, alu_res, lo[15:1]};
            cnt      <= cnt + 1'b1;
         end else if (state == S_DIV) begin
            hi  <= ok ? alu_res : sh;
            lo  <= {lo[14:0], ok};
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq: models the core ALU and checks results
// against plain arithmetic (x*y, x/y, x%y).
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op;
   logic [15:0] x;
   logic [15:0] y;
   logic        busy;
   logic        done;
   logic [15:0] hi;
   logic [15:0] lo;
   logic        dz;
   logic        alu_en;
   logic [3:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_res;
   logic        alu_c;

   int checks = 0;
   int errors = 0;

   alu_muldiv_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .x       (x),
      .y       (y),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo),
      .dz      (dz),
      .alu_en  (alu_en),
      .alu_op  (alu_op),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_res (alu_res),
      .alu_c   (alu_c)
   );

   always #5 clk = ~clk;

   // Shared core ALU: op 0 add with carry-out, op 1 subtract with borrow
   always_comb begin
      alu_res = 16'd0;
      alu_c   = 1'b0;
      case (alu_op)
         4'd0: {alu_c, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
         4'd1: begin
            alu_res = alu_a - alu_b;
            alu_c   = (alu_a < alu_b);
         end
         default: ;
      endcase
   end

   // Expected {hi, lo, dz} from arithmetic
   function automatic logic [32:0] model(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic o);
      logic [31:0] p;
      if (!o) begin
         p = 32'(a) * 32'(b);
         return {p, 1'b0};
      end else if (b == 16'd0) begin
         return {a, 16'hFFFF, 1'b1};
      end else begin
         return {a % b, a / b, 1'b0};
      end
   endfunction

   // Issue one request and wait for done; lat counts cycles after accept
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic o, output int lat, output int en);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      x     = a;
      y     = b;
      @(posedge clk);
      lat = 0;
      en  = 0;
      while (1) begin
         @(negedge clk);
         start = 1'b0;
         x     = 16'($urandom);
         y     = 16'($urandom);
         op    = 1'($urandom);
         lat++;
         if (alu_en) en++;
         if (done) break;
         if (lat >= 40) begin
            lat = -1;
            break;
         end
      end
   endtask

   task automatic check_op(input string name, input logic [15:0] a,
                           input logic [15:0] b, input logic o);
      int lat, en;
      logic [32:0] e;
      int exp_lat, exp_en;
      e = model(a, b, o);
      exp_lat = (o && b == 16'd0) ? 1 : 17;
      exp_en  = (o && b == 16'd0) ? 0 : 16;
      run_op(a, b, o, lat, en);
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (en !== exp_en) begin
         errors++;
         $display("FAIL %s alu_en cycles: got %0d want %0d", name, en, exp_en);
      end
      checks++;
      if ({hi, lo, dz} !== e) begin
         errors++;
         $display("FAIL %s result a=%h b=%h: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                  name, a, b, hi, lo, dz, e[32:17], e[16:1], e[0]);
      end
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      x     = 16'd0;
      y     = 16'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, dz, alu_en, hi, lo} !== 36'd0) begin
         errors++;
         $display("FAIL reset outputs: got busy=%b done=%b dz=%b en=%b hi=%h lo=%h want all 0",
                  busy, done, dz, alu_en, hi, lo);
      end
      checks++;
      if ({alu_op, alu_a, alu_b} !== 36'd0) begin
         errors++;
         $display("FAIL reset alu drive: got op=%h a=%h b=%h want 0",
                  alu_op, alu_a, alu_b);
      end
      rst = 1'b0;
   endtask

   task automatic test_mul;
      check_op("mul_1234x5678", 16'h1234, 16'h5678, 1'b0);
      check_op("mul_ffffxffff", 16'hFFFF, 16'hFFFF, 1'b0);
      check_op("mul_0x1234", 16'h0000, 16'h1234, 1'b0);
      for (int i = 0; i < 12; i++)
         check_op("mul_rand", 16'($urandom), 16'($urandom), 1'b0);
   endtask

   task automatic test_div;
      check_op("div_1000_7", 16'd1000, 16'd7, 1'b1);
      check_op("div_ffff_8001", 16'hFFFF, 16'h8001, 1'b1);
      for (int i = 0; i < 12; i++) begin
         logic [15:0] b;
         b = (i % 2 == 0) ? 16'($urandom_range(1, 255))
                          : 16'($urandom_range(1, 65535));
         check_op("div_rand", 16'($urandom), b, 1'b1);
      end
   endtask

   task automatic test_div0;
      check_op("div0", 16'h1234, 16'h0000, 1'b1);
      checks++;
      if ({alu_op, alu_a, alu_b} !== 36'd0) begin
         errors++;
         $display("FAIL div0 alu drive: got op=%h a=%h b=%h want 0",
                  alu_op, alu_a, alu_b);
      end
   endtask

   task automatic test_ignore_start;
      logic [15:0] a, b;
      logic [32:0] e;
      int early;
      a = 16'($urandom);
      b = 16'($urandom);
      e = model(a, b, 1'b0);
      early = 0;
      @(negedge clk);
      start = 1'b1;
      op    = 1'b0;
      x     = a;
      y     = b;
      for (int i = 1; i <= 17; i++) begin
         @(negedge clk);
         start = (i == 5 || i == 17);
         op    = 1'b1;
         x     = 16'($urandom);
         y     = 16'($urandom_range(1, 65535));
         if (i < 17 && done) early++;
      end
      checks++;
      if (early != 0 || done !== 1'b1) begin
         errors++;
         $display("FAIL ignore_done: got early=%0d done=%b want early=0 done=1",
                  early, done);
      end
      checks++;
      if ({hi, lo, dz} !== e) begin
         errors++;
         $display("FAIL ignore_result: got hi=%h lo=%h want hi=%h lo=%h",
                  hi, lo, e[32:17], e[16:1]);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {hi, lo, dz} !== e) begin
         errors++;
         $display("FAIL ignore_idle: got busy=%b done=%b hi=%h lo=%h want busy=0 done=0 hi=%h lo=%h",
                  busy, done, hi, lo, e[32:17], e[16:1]);
      end
      check_op("after_ignore", 16'd5000, 16'd3, 1'b1);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      start = 1'b1;
      op    = 1'b0;
      x     = 16'hBEEF;
      y     = 16'hCAFE;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      checks++;
      if (alu_en !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: got alu_en=%b want 1", alu_en);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, alu_en, dz, hi, lo} !== 36'd0) begin
         errors++;
         $display("FAIL rst_mid: got busy=%b done=%b en=%b dz=%b hi=%h lo=%h want all 0",
                  busy, done, alu_en, dz, hi, lo);
      end
      @(negedge clk);
      rst = 1'b0;
      check_op("after_rst", 16'd1000, 16'd7, 1'b1);
   endtask

   task automatic test_back_to_back;
      check_op("b2b_div0", 16'hABCD, 16'h0000, 1'b1);
      check_op("b2b_mul", 16'($urandom), 16'($urandom), 1'b0);
      check_op("b2b_div", 16'($urandom), 16'($urandom_range(1, 65535)), 1'b1);
      check_op("b2b_mul2", 16'hFFFF, 16'h0001, 1'b0);
   endtask

   initial begin
      test_reset;
      test_mul;
      test_div;
      test_div0;
      test_ignore_start;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
